// File: rtl/ram_arbiter_n.sv
// ram_arbiter_n: N-port arbiter and router in front of a single-port RAM.
// Fixed-priority or round-robin grant; rvalid returns through a tag pipeline.
module ram_arbiter_n #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter bit RR_MODE    = 1'b1,
  parameter int RD_LATENCY = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_PORTS-1:0]                port_req_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]     port_addr_i,
  input  logic [NUM_PORTS-1:0]                port_we_i,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]   port_be_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]     port_wdata_i,
  output logic [NUM_PORTS-1:0]                port_gnt_o,
  output logic [NUM_PORTS-1:0]                port_rvalid_o,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]     port_rdata_o,
  output logic                                ram_en_o,
  output logic [ADDR_WIDTH-1:0]               ram_addr_o,
  output logic                                ram_we_o,
  output logic [DATA_WIDTH/8-1:0]             ram_be_o,
  output logic [DATA_WIDTH-1:0]               ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]               ram_rdata_i
);

  localparam int BW = DATA_WIDTH / 8;
  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [IW-1:0]         r_rr_ptr;
  logic [RD_LATENCY-1:0] r_vld;
  logic [IW-1:0]         r_idx [RD_LATENCY];

  logic [NUM_PORTS-1:0]  w_req;
  logic                  w_found;
  logic [IW-1:0]         w_win;
  int                    w_base;
  int                    w_dist;
  int                    w_best;

  assign w_req = rst ? '0 : port_req_i;

  // Winner is the requester with the smallest rotated distance from the pointer.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_base  = RR_MODE ? int'(r_rr_ptr) : 0;
    w_dist  = 0;
    w_best  = NUM_PORTS;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_dist = i - w_base;
      if (w_dist < 0) w_dist = w_dist + NUM_PORTS;
      if (w_req[i] && (w_dist < w_best)) begin
        w_best  = w_dist;
        w_win   = IW'(i);
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    port_gnt_o  = '0;
    ram_en_o    = w_found;
    ram_addr_o  = '0;
    ram_we_o    = 1'b0;
    ram_be_o    = '0;
    ram_wdata_o = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_found && (w_win == IW'(i))) begin
        port_gnt_o[i] = 1'b1;
        ram_addr_o    = port_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        ram_we_o      = port_we_i[i];
        ram_be_o      = port_be_i[i*BW +: BW];
        ram_wdata_o   = port_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_vld    <= '0;
      for (int k = 0; k < RD_LATENCY; k++) r_idx[k] <= '0;
    end else begin
      r_vld[0] <= w_found;
      r_idx[0] <= w_win;
      for (int k = 1; k < RD_LATENCY; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_idx[k] <= r_idx[k-1];
      end
      if (w_found) begin
        r_rr_ptr <= (w_win == IW'(NUM_PORTS-1)) ? '0 : w_win + 1'b1;
      end
    end
  end

  always_comb begin
    port_rvalid_o = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      port_rvalid_o[i] = !rst && r_vld[RD_LATENCY-1] &&
                         (r_idx[RD_LATENCY-1] == IW'(i));
    end
  end

  assign port_rdata_o = {NUM_PORTS{ram_rdata_i}};

endmodule

// File: doc/ram_arbiter_n.md
# ram_arbiter_n

N-port arbiter and router placed in front of a single-port synchronous RAM (instruction or data memory). It lets any number of requesters share the RAM: the external bus, the core fetch port, the core load/store port and future DMA ports. It generalises the two-port fixed-priority memory mux in three ways:
- a parametrised port count;
- a selectable fixed-priority or round-robin arbitration mode;
- a parametrised RAM read latency, with `rvalid` routed back to the granted port through a pipeline.

## Interface
Parameters:
- `NUM_PORTS`, 4: number of requester ports, 2..8.
- `ADDR_WIDTH`, 16: word-address width of each port and of the RAM.
- `DATA_WIDTH`, 32: data width; byte-enable width is `DATA_WIDTH/8`.
- `RR_MODE`, 1: 0 = fixed priority (port 0 highest); 1 = round-robin.
- `RD_LATENCY`, 1: RAM cycles from enable to valid `ram_rdata_i`, 1..3.

Ports (vectors are packed; port i occupies slice i):
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `port_req_i` in `NUM_PORTS`: request per port.
- `port_addr_i` in `NUM_PORTS*ADDR_WIDTH`: address per port.
- `port_we_i` in `NUM_PORTS`: write enable per port.
- `port_be_i` in `NUM_PORTS*DATA_WIDTH/8`: byte enables per port.
- `port_wdata_i` in `NUM_PORTS*DATA_WIDTH`: write data per port.
- `port_gnt_o` out `NUM_PORTS`: one-hot grant, combinational.
- `port_rvalid_o` out `NUM_PORTS`: response valid per port.
- `port_rdata_o` out `NUM_PORTS*DATA_WIDTH`: read data, `ram_rdata_i` broadcast to every slice.
- `ram_en_o` out 1: RAM enable.
- `ram_addr_o` out `ADDR_WIDTH`: RAM address.
- `ram_we_o` out 1: RAM write enable.
- `ram_be_o` out `DATA_WIDTH/8`: RAM byte enables.
- `ram_wdata_o` out `DATA_WIDTH`: RAM write data.
- `ram_rdata_i` in `DATA_WIDTH`: RAM read data.

## Operation
- **One transaction per cycle.** At most one port is granted per cycle. `ram_en_o` is 1 exactly when some `port_gnt_o` bit is 1. The `ram_*` outputs carry the granted port's addr/we/be/wdata. When nothing is granted, the `ram_*` outputs are all zero.
- **Fixed mode (`RR_MODE`=0).** The lowest-index requesting port wins.
- **Round-robin mode (`RR_MODE`=1).**
  - A pointer `rr_ptr` (width `$clog2(NUM_PORTS)`) names the highest-priority port.
  - The winner is the first requesting port found scanning `rr_ptr`, `rr_ptr+1`, …, wrapping modulo `NUM_PORTS`.
  - On any grant, `rr_ptr` becomes (winner+1) mod `NUM_PORTS` at the next edge.
  - With no grant, `rr_ptr` holds.
  - The wrap must be correct when `NUM_PORTS` is not a power of two: the value after `NUM_PORTS-1` is 0.
- **Handshake.**
  - A requester holds `req` and its payload stable until it sees `gnt`.
  - The transfer is accepted in the cycle where `req` and `gnt` are both 1.
  - The requester may drop `req` or issue a new request the following cycle.
  - An ungranted request is never lost. It is re-arbitrated every cycle.
- **Response routing.**
  - A pipeline of depth `RD_LATENCY` holds, per stage, a valid bit and the granted port index.
  - Stage 0 loads {`ram_en_o`, winner index} on each edge.
  - `port_rvalid_o[i]` is 1 when the last stage is valid and its index equals i.
  - Writes also produce `rvalid`, with the same latency, as a write acknowledge.
  - `port_rdata_o` is meaningful only when `rvalid` is asserted.
- **Back-to-back.** Full throughput: a new grant every cycle, responses returning in order, with a single response per cycle.

## Timing
- **Grant.** Grant is combinational, issued in the same cycle as `req` (0-cycle arbitration latency).
- **Response.** `rvalid` for a transfer accepted at edge n is asserted in the cycle following edge n+`RD_LATENCY`-1.
  - For `RD_LATENCY`=1, this is the cycle immediately after the grant cycle.
  - `rvalid` is aligned with `ram_rdata_i`.
- **Reset values and behaviour while `rst`=1.**
  - `rr_ptr`=0; all pipeline valid bits are 0.
  - `port_rvalid_o`=0 and `port_gnt_o`=0; all `ram_*` outputs are 0, including `ram_en_o`=0.
  - Requests are ignored while `rst` is 1.
- **Reset mid-operation.**
  - In-flight responses are discarded: no `rvalid` is asserted in the cycle after reset, even if a transfer was granted before it.
  - The first arbitration after reset starts from port 0.
- **Simultaneous events.**
  - All ports requesting: exactly one grant.
  - A grant and an `rvalid` on the same port in the same cycle are legal, because of pipelining.
  - A port that is granted every cycle in round-robin mode still rotates priority.
- **Arithmetic.** Index comparisons use `$clog2(NUM_PORTS)` bits. Out-of-range pointer values are unreachable.

## Test plan
- **Reset.** Hold `rst` 3 cycles with all `req`=1 → `gnt`=0, `ram_en_o`=0, `rvalid`=0. In the first cycle after reset, port 0 is granted in both modes.
- **Fixed priority.** `RR_MODE`=0, ports 1 and 3 requesting continuously for 4 cycles → port 1 granted in all 4 cycles and port 3 never. With `RD_LATENCY`=2, `port_rvalid_o` = 4'b0010 starting 2 cycles after the first grant.
- **Round-robin.** `RR_MODE`=1, `NUM_PORTS`=3, all ports requesting for 6 cycles → grant sequence 0,1,2,0,1,2. A second run with only port 2 requesting grants port 2 every cycle, with `rr_ptr` wrapping 2→0.
- **Data routing.**
  - Port 0 writes addr 0x10, data 0xDEADBEEF, be 4'hF.
  - Then port 2 reads addr 0x10.
  - → port 0 gets a write-ack `rvalid`; port 2 gets `rvalid` with rdata 0xDEADBEEF after `RD_LATENCY` cycles; no other port sees `rvalid`.
- **Back-to-back.** Ports 0 and 1 each issue 8 reads at 100% request rate → 16 grants in 16 cycles, with responses in grant order and correct port tags.
- **Mid-flight reset.** Grant a read to port 1, then assert `rst` on the next cycle → no `port_rvalid_o` asserted during reset or afterwards; `rr_ptr` reads 0.
